// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-order record of issued instructions (rd, we, late).
// Raises a decode stall when a source's youngest in-flight writer is a
// late producer that cannot be bypassed yet. Drains at writeback, clears on flush.

// Per-slot decode: liveness of the slot and source-register matches.
module hs_slot #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3,
  parameter int PTR_W = 2,
  parameter int SLOT  = 0
) (
  input  logic [PTR_W-1:0] head,
  input  logic [CNT_W-1:0] cnt,
  input  logic             retire_valid,
  input  logic [4:0]       rd,
  input  logic             we,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             hit1,
  output logic             hit2
);
  logic [PTR_W-1:0] off;
  logic             live;

  // Age of this slot relative to head; the retiring head is covered by MEM/WB forwarding.
  always_comb begin
    off  = PTR_W'(SLOT) - head;
    live = (CNT_W'(off) < cnt) && !((off == '0) && retire_valid);
    hit1 = live && we && (rd == rs1);
    hit2 = live && we && (rd == rs2);
  end
endmodule

module hazard_scoreboard #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic             issue_we,
  input  logic             issue_late,
  input  logic [4:0]       query_rs1,
  input  logic [4:0]       query_rs2,
  input  logic             query_rs1_used,
  input  logic             query_rs2_used,
  input  logic             retire_valid,
  input  logic [4:0]       retire_rd,
  input  logic             flush,
  output logic             stall,
  output logic [CNT_W-1:0] occupancy,
  output logic [31:0]      late_mask,
  output logic             protocol_error
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       late;
  } ent_t;

  ent_t [DEPTH-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mask_q, mask_d;
  logic             perr_q, perr_d;

  logic [DEPTH-1:0] hit1, hit2;
  logic             haz1, haz2, full, push, pop;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    hs_slot #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PTR_W(PTR_W), .SLOT(g)) u_slot (
      .head         (head_q),
      .cnt          (cnt_q),
      .retire_valid (retire_valid),
      .rd           (fifo_q[g].rd),
      .we           (fifo_q[g].we),
      .rs1          (query_rs1),
      .rs2          (query_rs2),
      .hit1         (hit1[g]),
      .hit2         (hit2[g])
    );
  end

  // Walk oldest to youngest so the last matching writer decides the hazard.
  always_comb begin
    logic [PTR_W-1:0] idx;
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (hit1[idx]) haz1 = fifo_q[idx].late;
      if (hit2[idx]) haz2 = fifo_q[idx].late;
    end
    haz1 = haz1 && query_rs1_used && (query_rs1 != 5'd0);
    haz2 = haz2 && query_rs2_used && (query_rs2 != 5'd0);
    full  = (cnt_q == CNT_W'(DEPTH));
    stall = haz1 || haz2 || (full && !retire_valid);
  end

  // Next FIFO state, error flag and the late mask of the post-update contents.
  always_comb begin
    logic [PTR_W-1:0] off;
    push   = issue_valid && !stall && !flush;
    pop    = retire_valid && (cnt_q != '0);
    fifo_d = fifo_q;
    if (push) begin
      fifo_d[tail_q].rd   = issue_rd;
      fifo_d[tail_q].we   = issue_we && (issue_rd != 5'd0);
      fifo_d[tail_q].late = issue_late;
    end
    tail_d = push ? tail_q + PTR_W'(1) : tail_q;
    head_d = pop  ? head_q + PTR_W'(1) : head_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    if (flush) begin
      head_d = tail_q;
      tail_d = tail_q;
      cnt_d  = '0;
    end
    perr_d = perr_q;
    if (retire_valid && ((cnt_q == '0) ||
        (fifo_q[head_q].we && (fifo_q[head_q].rd != retire_rd))))
      perr_d = 1'b1;
    mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - head_d;
      if ((CNT_W'(off) < cnt_d) && fifo_d[i].we && fifo_d[i].late)
        mask_d[fifo_d[i].rd] = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      mask_q <= '0;
      perr_q <= 1'b0;
    end else begin
      fifo_q <= fifo_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      perr_q <= perr_d;
    end
  end

  assign occupancy      = cnt_q;
  assign late_mask      = mask_q;
  assign protocol_error = perr_q;
endmodule
